// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl
//
// Pipeline hazard and memory-stall controller for a 5-stage in-order core.
// Detects load-use hazards between ID/EX and IF/ID. It also tracks an
// outstanding data-memory access with a two-state FSM (RUN / MEMWAIT).
// From these it drives the pipeline freeze, bubble and write-enable controls.
// A wait counter raises a sticky timeout error when memory never answers.
// Saturating counters record how many cycles were spent stalled or bubbling.
//
// Parameters
//   TIMEOUT        maximum memory-wait cycles before Err_o sets (1..255)
//
// Ports
//   clk_i          clock, all state updates on rising edge
//   rst_i          asynchronous active-high reset
//   IDEX_MemRead_i ID/EX instruction is a load
//   IDEX_RegRt_i   load destination register in ID/EX
//   IFID_RegRs_i   rs source of the IF/ID instruction
//   IFID_RegRt_i   rt field of the IF/ID instruction
//   IFID_UsesRt_i  IF/ID instruction reads rt as a source
//   MemReq_i       MEM stage issues a data-memory access this cycle
//   MemAck_i       data memory completes the access this cycle
//   Stall_o        freeze ID/EX, EX/MEM and MEM/WB
//   PCWrite_o      PC update enable
//   IFIDWrite_o    IF/ID update enable
//   Bubble_o       zero the control fields entering ID/EX
//   State_o        FSM state, 0 = RUN, 1 = MEMWAIT
//   Err_o          sticky memory-timeout error
//   StallCnt_o     saturating count of cycles with Stall_o = 1
//   BubbleCnt_o    saturating count of cycles with Bubble_o = 1
// ============================================================================
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegRt_i,
    input  logic [4:0]  IFID_RegRs_i,
    input  logic [4:0]  IFID_RegRt_i,
    input  logic        IFID_UsesRt_i,
    input  logic        MemReq_i,
    input  logic        MemAck_i,
    output logic        Stall_o,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        Bubble_o,
    output logic        State_o,
    output logic        Err_o,
    output logic [15:0] StallCnt_o,
    output logic [15:0] BubbleCnt_o
);

    localparam logic [7:0]  LP_TIMEOUT  = TIMEOUT[7:0];
    localparam logic [7:0]  LP_WAIT_MAX = 8'hFF;
    localparam logic [15:0] LP_CNT_MAX  = 16'hFFFF;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_err;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    logic        w_memstall;
    logic        w_loaduse;
    logic        w_rs_match;
    logic        w_rt_match;
    logic        w_bubble;

    // ------------------------------------------------------------------
    // Combinational hazard detection
    // ------------------------------------------------------------------

    // The access is outstanding either because it is being issued now or
    // because an earlier one is still waiting. An ack in the same cycle
    // resolves it, so a hit never stalls.
    assign w_memstall = (MemReq_i || (r_state == MEMWAIT)) && !MemAck_i;

    assign w_rs_match = (IDEX_RegRt_i == IFID_RegRs_i);
    assign w_rt_match = IFID_UsesRt_i && (IDEX_RegRt_i == IFID_RegRt_i);

    // Register 0 is hard-wired to zero, so a load into it is never a hazard.
    assign w_loaduse  = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                        (w_rs_match || w_rt_match);

    // While the memory stall holds ID/EX, the load cannot advance. Inserting
    // a bubble would therefore destroy the held instruction. The hazard is
    // re-evaluated each cycle and turns into a single bubble once the
    // stall clears.
    assign w_bubble   = w_loaduse && !w_memstall;

    assign Stall_o     = w_memstall;
    assign Bubble_o    = w_bubble;
    assign PCWrite_o   = !(w_memstall || w_loaduse);
    assign IFIDWrite_o = !(w_memstall || w_loaduse);

    assign State_o     = r_state;
    assign Err_o       = r_err;
    assign StallCnt_o  = r_stall_cnt;
    assign BubbleCnt_o = r_bubble_cnt;

    // ------------------------------------------------------------------
    // FSM, wait counter, timeout flag and statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (MemReq_i && !MemAck_i) begin
                        r_state <= MEMWAIT;
                    end
                end
                MEMWAIT: begin
                    if (MemAck_i) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            // The ack clears the counter. The counter otherwise counts
            // stalled edges and parks at its maximum value.
            if (MemAck_i) begin
                r_wait_cnt <= '0;
            end else if (w_memstall && (r_wait_cnt != LP_WAIT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Sticky error: the FSM keeps waiting, software inspects Err_o.
            if (w_memstall && (r_wait_cnt == LP_TIMEOUT)) begin
                r_err <= 1'b1;
            end

            if (w_memstall && (r_stall_cnt != LP_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end

            if (w_bubble && (r_bubble_cnt != LP_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// tb_hazard_stall_ctrl
//
// Self-checking bench for hazard_stall_ctrl (TIMEOUT = 4). The bench first
// runs directed scenarios and then a randomized phase. A behavioural model
// predicts every output each cycle. Inputs change after the falling edge
// and outputs are sampled 1 ns later.
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_memrd = 1'b0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  if_rs = '0;
    logic [4:0]  if_rt = '0;
    logic        if_uses_rt = 1'b0;
    logic        mreq = 1'b0;
    logic        mack = 1'b0;

    logic        stall, pcw, ifidw, bubble, state, err;
    logic [15:0] stall_cnt, bubble_cnt;

    hazard_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IDEX_MemRead_i (id_memrd),
        .IDEX_RegRt_i   (id_rt),
        .IFID_RegRs_i   (if_rs),
        .IFID_RegRt_i   (if_rt),
        .IFID_UsesRt_i  (if_uses_rt),
        .MemReq_i       (mreq),
        .MemAck_i       (mack),
        .Stall_o        (stall),
        .PCWrite_o      (pcw),
        .IFIDWrite_o    (ifidw),
        .Bubble_o       (bubble),
        .State_o        (state),
        .Err_o          (err),
        .StallCnt_o     (stall_cnt),
        .BubbleCnt_o    (bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_waiting;
    int m_wait;
    bit m_err;
    int m_stalls;
    int m_bubbles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_waiting = 0; m_wait = 0; m_err = 0; m_stalls = 0; m_bubbles = 0;
    endfunction

    function automatic bit m_memstall();
        return (mreq || m_waiting) && !mack;
    endfunction

    function automatic bit m_loaduse();
        if (!id_memrd || id_rt == 0) return 0;
        return (id_rt == if_rs) || (if_uses_rt && id_rt == if_rt);
    endfunction

    task automatic check_all();
        bit ms, lu;
        ms = m_memstall();
        lu = m_loaduse();
        check("stall",  32'(stall),  32'(ms));
        check("bubble", 32'(bubble), 32'(lu && !ms));
        check("pcw",    32'(pcw),    32'(!(ms || lu)));
        check("ifidw",  32'(ifidw),  32'(!(ms || lu)));
        check("state",  32'(state),  32'(m_waiting));
        check("err",    32'(err),    32'(m_err));
        check("scnt",   32'(stall_cnt),  32'(m_stalls));
        check("bcnt",   32'(bubble_cnt), 32'(m_bubbles));
    endtask

    // One clock cycle: check outputs, then clock the model with the same inputs.
    task automatic tick();
        bit ms, bub;
        #1;
        if (rst) model_reset();
        check_all();
        @(posedge clk);
        if (!rst) begin
            ms  = m_memstall();
            bub = m_loaduse() && !ms;
            if (ms && m_wait == TO) m_err = 1;
            if (mack) m_wait = 0;
            else if (ms && m_wait < 255) m_wait++;
            if (ms && m_stalls < 65535) m_stalls++;
            if (bub && m_bubbles < 65535) m_bubbles++;
            if (!m_waiting) m_waiting = mreq && !mack;
            else m_waiting = !mack;
        end
        @(negedge clk);
    endtask

    task automatic set_haz(input bit rd, input int rt, input int rs, input int frt, input bit use_rt);
        id_memrd = rd; id_rt = 5'(rt); if_rs = 5'(rs); if_rt = 5'(frt); if_uses_rt = use_rt;
    endtask

    task automatic do_reset();
        rst = 1; mreq = 0; mack = 0; set_haz(0, 0, 0, 0, 0);
        tick();
        rst = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_scnt",  32'(stall_cnt), 32'd0);

        // Load-use on rs: exactly one bubble
        set_haz(1, 5, 5, 0, 0);
        tick();
        set_haz(0, 0, 0, 0, 0);
        tick();
        check("lu_bcnt", 32'(bubble_cnt), 32'd1);

        // Register 0 never hazards; rt match ignored without UsesRt; with it, hazards
        set_haz(1, 0, 0, 0, 1); tick();
        set_haz(1, 7, 3, 7, 0); tick();
        set_haz(1, 7, 3, 7, 1); tick();
        set_haz(0, 7, 7, 7, 1); tick();
        set_haz(0, 0, 0, 0, 0);

        // Miss: ack on the 4th cycle -> 3 stalled cycles
        do_reset();
        mreq = 1; tick(); tick(); tick();
        mack = 1; tick();
        mreq = 0; mack = 0; tick();
        check("miss_scnt",  32'(stall_cnt), 32'd3);
        check("miss_state", 32'(state), 32'd0);

        // Hit: req and ack together, no stall, no transition
        mreq = 1; mack = 1; tick();
        mreq = 0; mack = 0; tick();
        check("hit_scnt", 32'(stall_cnt), 32'd3);

        // Priority: load-use during a 2-cycle miss, then one bubble
        do_reset();
        set_haz(1, 9, 9, 0, 0);
        mreq = 1; tick(); tick();
        mack = 1; mreq = 0; tick();   // ack cycle: memstall drops, bubble
        mack = 0; set_haz(0, 0, 0, 0, 0); tick();
        check("prio_bcnt", 32'(bubble_cnt), 32'd1);
        check("prio_scnt", 32'(stall_cnt), 32'd2);

        // Timeout: ack withheld; error after the 5th stalled edge
        do_reset();
        mreq = 1; tick(); mreq = 0;
        for (int i = 0; i < 3; i++) tick();
        check("to_err4", 32'(err), 32'd0);
        tick();
        check("to_err5", 32'(err), 32'd1);
        tick(); tick();
        mack = 1; tick(); mack = 0; tick();
        check("to_sticky", 32'(err), 32'd1);

        // Async reset mid-wait, no clock edge
        mreq = 1; tick(); mreq = 0; tick();
        #2 rst = 1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_err",   32'(err), 32'd0);
        check("arst_scnt",  32'(stall_cnt), 32'd0);
        check("arst_bcnt",  32'(bubble_cnt), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        model_reset();
        tick();
        rst = 0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            id_memrd   = $urandom_range(0, 1);
            id_rt      = 5'($urandom_range(0, 3));
            if_rs      = 5'($urandom_range(0, 3));
            if_rt      = 5'($urandom_range(0, 3));
            if_uses_rt = $urandom_range(0, 1);
            mreq       = ($urandom_range(0, 2) == 0);
            mack       = ($urandom_range(0, 7) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum memory-wait cycles before the error flag sets (range 1..255).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port IDEX_MemRead_i, input, 1 bit: the instruction in ID/EX is a load.
REQ-005 The block SHALL have port IDEX_RegRt_i, input, 5 bits: the load destination register in ID/EX.
REQ-006 The block SHALL have port IFID_RegRs_i, input, 5 bits: the rs source of the instruction in IF/ID.
REQ-007 The block SHALL have port IFID_RegRt_i, input, 5 bits: the rt field of the instruction in IF/ID.
REQ-008 The block SHALL have port IFID_UsesRt_i, input, 1 bit: the IF/ID instruction reads rt as a source.
REQ-009 The block SHALL have port MemReq_i, input, 1 bit: the MEM stage issues a data-memory access this cycle.
REQ-010 The block SHALL have port MemAck_i, input, 1 bit: the data memory completes the access this cycle.
REQ-011 The block SHALL have port Stall_o, output, 1 bit: freeze ID/EX, EX/MEM and MEM/WB (drives their stall_i).
REQ-012 The block SHALL have port PCWrite_o, output, 1 bit: PC update enable.
REQ-013 The block SHALL have port IFIDWrite_o, output, 1 bit: IF/ID update enable.
REQ-014 The block SHALL have port Bubble_o, output, 1 bit: zero the WB, MEM and EX control fields entering ID/EX.
REQ-015 The block SHALL have port State_o, output, 1 bit: FSM state, 0=RUN, 1=MEMWAIT.
REQ-016 The block SHALL have port Err_o, output, 1 bit: sticky memory-timeout error.
REQ-017 The block SHALL have port StallCnt_o, output, 16 bits: saturating count of cycles with Stall_o=1.
REQ-018 The block SHALL have port BubbleCnt_o, output, 16 bits: saturating count of cycles with Bubble_o=1.

Function
REQ-019 memstall SHALL equal ((MemReq_i or State_o=MEMWAIT) and not MemAck_i), computed combinationally in the same cycle.
REQ-020 loaduse SHALL equal IDEX_MemRead_i and IDEX_RegRt_i!=0 and (IDEX_RegRt_i==IFID_RegRs_i or (IFID_UsesRt_i and IDEX_RegRt_i==IFID_RegRt_i)), computed combinationally.
REQ-021 Stall_o SHALL equal memstall.
REQ-022 Bubble_o SHALL equal loaduse and not memstall; memory stall takes priority because ID/EX is held.
REQ-023 PCWrite_o and IFIDWrite_o SHALL both equal not (memstall or loaduse).
REQ-024 The FSM SHALL move RUN->MEMWAIT on a clock edge where MemReq_i=1 and MemAck_i=0.
REQ-025 The FSM SHALL move MEMWAIT->RUN on a clock edge where MemAck_i=1.
REQ-026 In all other cases the FSM SHALL hold its state; MemAck_i in RUN with MemReq_i=1 (a hit) SHALL cause no stall and no transition.
REQ-027 An 8-bit wait counter SHALL increment on each edge where memstall=1, saturate at 255, and clear on any edge where MemAck_i=1.
REQ-028 Err_o SHALL set on the edge where the wait counter equals TIMEOUT while memstall=1, and SHALL remain set until reset; the FSM SHALL keep waiting after Err_o sets.
REQ-029 StallCnt_o and BubbleCnt_o SHALL increment on each edge where the corresponding output is 1, and SHALL hold at 16'hFFFF once reached.
REQ-030 A load-use hazard detected while memstall=1 SHALL be re-evaluated each cycle and SHALL produce exactly one Bubble_o cycle after memstall drops, if the hazard still holds.

Reset
REQ-031 While rst_i=1, independent of clk_i: the FSM SHALL be RUN, Err_o=0, wait counter=0, StallCnt_o=0, BubbleCnt_o=0.
REQ-032 During reset, combinational outputs SHALL follow REQ-019..023 using State_o=RUN.
REQ-033 Reset asserted in MEMWAIT SHALL immediately force RUN; Stall_o then depends only on MemReq_i and MemAck_i.

Verification
REQ-034 Load-use hazard: IDEX_MemRead_i=1, IDEX_RegRt_i=5, IFID_RegRs_i=5, no memory request -> Bubble_o=1, PCWrite_o=0, IFIDWrite_o=0 for 1 cycle, BubbleCnt_o=1.
REQ-035 Register 0 and unused rt: IDEX_RegRt_i=0, or a match on IFID_RegRt_i with IFID_UsesRt_i=0 -> Bubble_o=0, PCWrite_o=1.
REQ-036 Memory miss: MemReq_i=1 with MemAck_i=1 on the 4th cycle -> Stall_o=1 for 3 cycles, State_o=1 for 3 cycles then 0, StallCnt_o=3.
REQ-037 Priority: a load-use hazard concurrent with a 2-cycle miss -> Bubble_o=0 during the stall, then exactly 1 Bubble_o cycle.
REQ-038 Timeout: TIMEOUT=4 and MemAck_i withheld -> Err_o=1 after the 5th stalled edge and stays 1 after MemAck_i; rst_i mid-wait -> State_o=0, Err_o=0, counters=0 without a clock edge.
